// File: rtl/cycle_measure_ctrl.sv
// Sequencing controller for the single-channel period measurer.
// A start command opens the pulse gate, throws away the first (possibly
// partial) period sample, then collects 2^LOG2_AVG samples and reports
// their truncated average, minimum and maximum. A stalled input ends the
// run with timeout_err. Abort cancels a run without touching the results.
//
// Handshake: start, abort and meas_valid are single-cycle strobes with no
// back-pressure. meas_count is only looked at in a cycle where meas_valid
// is high. done is a 1-cycle strobe. When done is high, the results and
// timeout_err are already valid and stay stable until the next done.
module cycle_measure_ctrl #(
  parameter int CNT_W    = 30,
  parameter int LOG2_AVG = 3,
  parameter int TIMEOUT  = 100000000,
  parameter int TO_W     = 27
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pulse_in,
  output logic             pulse_gated,
  input  logic [CNT_W-1:0] meas_count,
  input  logic             meas_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] avg_count,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2
  } state_t;

  localparam int ACC_W = CNT_W + LOG2_AVG;
  localparam int SC_W  = LOG2_AVG + 1;
  localparam logic [SC_W-1:0] LAST_IDX = SC_W'((1 << LOG2_AVG) - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              gate_en;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [SC_W-1:0]   sample_cnt;
  logic [TO_W-1:0]   timer;
  logic [CNT_W-1:0]  run_min;
  logic [CNT_W-1:0]  run_max;
  logic [CNT_W-1:0]  new_min;
  logic [CNT_W-1:0]  new_max;

  // Decoded events for the current cycle. These are driven by the FSM.
  logic accept;     // start taken in IDLE
  logic sample;     // meas_valid counted in ACCUM
  logic finish_ok;  // the sample that completes the set
  logic finish_to;  // no sample arrived within the timeout window
  logic cancel;     // abort during a run

  // The gate follows a register, so a glitch on start cannot reach the measurer.
  assign pulse_gated = pulse_in & gate_en;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  // The running sum and the extremes include the current sample. This way
  // the last sample goes straight into the reported results.
  assign acc_sum = acc + ACC_W'(meas_count);
  assign new_min = (meas_count < run_min) ? meas_count : run_min;
  assign new_max = (meas_count > run_max) ? meas_count : run_max;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and event decode. abort beats everything. A valid beats the timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    cancel    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else if (meas_valid) begin
          state_nxt = ACCUM;
        end else if (timer == TO_LAST) begin
          finish_to = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else if (meas_valid) begin
          sample = 1'b1;
          if (sample_cnt == LAST_IDX) begin
            finish_ok = 1'b1;
            state_nxt = IDLE;
          end
        end else if (timer == TO_LAST) begin
          finish_to = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: gate, timer, accumulation and result registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gate_en     <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      acc         <= '0;
      sample_cnt  <= '0;
      timer       <= '0;
      run_min     <= '0;
      run_max     <= '0;
      avg_count   <= '0;
      min_count   <= '0;
      max_count   <= '0;
    end else begin
      done <= finish_ok | finish_to;

      // The timer measures the gap since the last valid or the run start.
      if (state != IDLE) begin
        if (meas_valid) timer <= '0;
        else            timer <= timer + TO_W'(1);
      end

      if (accept) begin
        gate_en     <= 1'b1;
        timeout_err <= 1'b0;
        acc         <= '0;
        sample_cnt  <= '0;
        timer       <= '0;
        run_min     <= '1;
        run_max     <= '0;
      end

      if (sample) begin
        acc        <= acc_sum;
        sample_cnt <= sample_cnt + SC_W'(1);
        run_min    <= new_min;
        run_max    <= new_max;
      end

      if (finish_ok) begin
        gate_en   <= 1'b0;
        avg_count <= acc_sum[ACC_W-1:LOG2_AVG];
        min_count <= new_min;
        max_count <= new_max;
      end

      if (finish_to) begin
        gate_en     <= 1'b0;
        timeout_err <= 1'b1;
      end

      if (cancel) gate_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cycle_measure_ctrl.sv
// Bench for cycle_measure_ctrl. It uses a short timeout and 4-sample averaging.
// The reference model works on each run as a list of samples. It predicts
// the average with integer division, and min/max by scanning the list.
module tb_cycle_measure_ctrl;

  localparam int CNT_W    = 16;
  localparam int LOG2_AVG = 2;
  localparam int N        = 4;
  localparam int TIMEOUT  = 50;
  localparam int TO_W     = 6;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             start;
  logic             abort;
  logic             pulse_in;
  logic             pulse_gated;
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] avg_count;
  logic [CNT_W-1:0] min_count;
  logic [CNT_W-1:0] max_count;
  logic [1:0]       state_dbg;

  cycle_measure_ctrl #(
    .CNT_W(CNT_W), .LOG2_AVG(LOG2_AVG), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .pulse_in(pulse_in), .pulse_gated(pulse_gated), .meas_count(meas_count),
    .meas_valid(meas_valid), .busy(busy), .done(done), .timeout_err(timeout_err),
    .avg_count(avg_count), .min_count(min_count), .max_count(max_count),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done_cnt = 0;
  logic [CNT_W-1:0] exp_avg = '0;
  logic [CNT_W-1:0] exp_min = '0;
  logic [CNT_W-1:0] exp_max = '0;
  logic [CNT_W-1:0] smp [N];
  // Scoreboard of finished results, oldest first: {avg, min, max}
  logic [3*CNT_W-1:0] exp_q[$];

  // Count every done pulse that is seen
  always @(negedge sys_clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait out `gap` idle cycles, then deliver one valid sample. If poke is
  // set, stray start strobes may be sent while the run is in progress.
  task automatic send_valid(input logic [CNT_W-1:0] v, input int gap, input bit poke);
    repeat (gap) begin
      if (poke && $urandom_range(0, 3) == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    meas_count = v;
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    meas_count = CNT_W'($urandom_range(0, 65535));
  endtask

  task automatic set_smp(input int a, input int b, input int c, input int d);
    smp[0] = CNT_W'(a); smp[1] = CNT_W'(b); smp[2] = CNT_W'(c); smp[3] = CNT_W'(d);
  endtask

  // A full good run over smp[]. The gaps are drawn from [gap_lo, gap_hi].
  task automatic good_run(input int gap_lo, input int gap_hi, input bit poke);
    longint sum;
    logic [CNT_W-1:0] mn, mx;
    logic [3*CNT_W-1:0] res;
    do_start();
    check_eq("busy_after_start", busy, 1);
    check_eq("terr_cleared", timeout_err, 0);
    pulse_in = 1'b1; #1;
    check_eq("gate_open", pulse_gated, 1);
    pulse_in = 1'b0; #1;
    check_eq("gate_low_in", pulse_gated, 0);
    send_valid(CNT_W'($urandom_range(0, 65535)), $urandom_range(gap_lo, gap_hi), poke);
    sum = 0; mn = '1; mx = '0;
    for (int i = 0; i < N; i++) begin
      sum += longint'(smp[i]);
      if (smp[i] < mn) mn = smp[i];
      if (smp[i] > mx) mx = smp[i];
    end
    exp_q.push_back({CNT_W'(sum / N), mn, mx});
    for (int i = 0; i < N; i++) send_valid(smp[i], $urandom_range(gap_lo, gap_hi), poke);
    // One cycle after the last valid sample
    check_eq("done_strobe", done, 1);
    check_eq("no_early_done", done_cnt, exp_done_cnt);
    exp_done_cnt++;
    res = exp_q.pop_front();
    exp_avg = res[3*CNT_W-1:2*CNT_W];
    exp_min = res[2*CNT_W-1:CNT_W];
    exp_max = res[CNT_W-1:0];
    check_eq("busy_end", busy, 0);
    check_eq("avg", avg_count, exp_avg);
    check_eq("min", min_count, exp_min);
    check_eq("max", max_count, exp_max);
    check_eq("terr_good", timeout_err, 0);
    pulse_in = 1'b1; #1;
    check_eq("gate_closed", pulse_gated, 0);
    pulse_in = 1'b0;
    tick();
    check_eq("done_one_cycle", done, 0);
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_avg"}, avg_count, exp_avg);
    check_eq({tag, "_min"}, min_count, exp_min);
    check_eq({tag, "_max"}, max_count, exp_max);
  endtask

  // Start a run, drop the first sample, then accept two real samples
  task automatic partial_run();
    do_start();
    send_valid(CNT_W'($urandom_range(0, 65535)), 3, 1'b0);
    send_valid(CNT_W'($urandom_range(0, 65535)), 2, 1'b0);
    send_valid(CNT_W'($urandom_range(0, 65535)), 4, 1'b0);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int nb;
    int it;
    sys_rst_n = 1'b0; start = 1'b0; abort = 1'b0; pulse_in = 1'b1;
    meas_count = '0; meas_valid = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_terr", timeout_err, 0);
    check_eq("rst_gate", pulse_gated, 0);
    check_results("rst");
    sys_rst_n = 1'b1; pulse_in = 1'b0;
    tick();

    // Steady 10-cycle period
    set_smp(10, 10, 10, 10);
    good_run(9, 9, 1'b0);
    // Spread values, then truncation
    set_smp(8, 12, 10, 14);
    good_run(0, 6, 1'b0);
    set_smp(8, 8, 8, 9);
    good_run(0, 6, 1'b1);
    // Value boundaries
    set_smp(0, 65535, 0, 65535);
    good_run(0, 3, 1'b0);
    set_smp(65535, 65535, 65535, 65535);
    good_run(0, 3, 1'b0);
    // Every gap lands exactly on the last timer cycle, so each valid wins
    set_smp(3, 1, 4, 1);
    good_run(TIMEOUT - 1, TIMEOUT - 1, 1'b0);

    // Timeout: the previous results must hold
    do_start();
    nb = 0; it = 0;
    while (done !== 1'b1 && it < 3 * TIMEOUT) begin
      if (busy) nb++;
      it++;
      tick();
    end
    check_eq("to_done", done, 1);
    check_eq("to_busy_cycles", nb, TIMEOUT);
    check_eq("to_terr", timeout_err, 1);
    check_eq("to_busy", busy, 0);
    check_results("to_hold");
    exp_done_cnt++;
    repeat (3) tick();
    check_eq("to_terr_held", timeout_err, 1);

    // Abort after two accepted samples
    partial_run();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_busy", busy, 0);
    pulse_in = 1'b1; #1;
    check_eq("ab_gate", pulse_gated, 0);
    pulse_in = 1'b0;
    check_eq("ab_terr", timeout_err, 0);
    send_valid(CNT_W'(5), 2, 1'b0);
    repeat (TIMEOUT + 5) tick();
    check_eq("ab_no_done", done_cnt, exp_done_cnt);
    check_results("ab_hold");
    set_smp(20, 20, 20, 20);
    good_run(19, 19, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("sa_idle", busy, 0);
    tick();
    check_eq("sa_idle2", busy, 0);

    // Randomized runs with stray starts
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       smp[i] = '0;
          1:       smp[i] = '1;
          default: smp[i] = CNT_W'($urandom_range(0, 65535));
        endcase
      end
      good_run(0, $urandom_range(0, TIMEOUT - 1), 1'b1);
    end

    // Reset in the middle of a run
    partial_run();
    #2;
    sys_rst_n = 1'b0;
    pulse_in = 1'b1;
    #1;
    check_eq("mr_busy", busy, 0);
    check_eq("mr_done", done, 0);
    check_eq("mr_terr", timeout_err, 0);
    check_eq("mr_gate", pulse_gated, 0);
    exp_avg = '0; exp_min = '0; exp_max = '0;
    check_results("mr");
    tick();
    sys_rst_n = 1'b1;
    pulse_in = 1'b0;
    for (int k = 0; k < 6; k++) send_valid(CNT_W'($urandom_range(0, 65535)), 2, 1'b0);
    repeat (TIMEOUT + 5) tick();
    check_eq("mr_no_done", done_cnt, exp_done_cnt);
    check_eq("mr_idle", busy, 0);

    check_eq("done_total", done_cnt, exp_done_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
